// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity link: FSM encoding and parity-mode constants.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_tx.sv
// Serial parity transmitter: shifts a WIDTH-bit word out LSB-first, then appends
// one parity bit so the whole frame carries the configured parity.
module parity_tx
    import parity_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter bit          ODD   = PAR_ODD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_end
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] sh, sh_nx;
    logic             acc, acc_nx;
    logic             out_nx, vld_nx, fe_nx;
    logic             accept;

    // acc holds the XOR of every data bit already driven onto out
    function automatic logic parity_bit(input logic xor_of_data);
        return (ODD == PAR_EVEN) ? xor_of_data : ~xor_of_data;
    endfunction

    assign ready  = reset && (state == IDLE || state == PARITY);
    assign accept = load && ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            acc       <= 1'b0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            sh        <= sh_nx;
            acc       <= acc_nx;
            out       <= out_nx;
            out_valid <= vld_nx;
            frame_end <= fe_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sh_nx    = sh;
        acc_nx   = acc;
        out_nx   = out;
        vld_nx   = out_valid;
        fe_nx    = frame_end;

        case (state)
            SHIFT: begin
                if (cnt == LAST) begin
                    out_nx   = parity_bit(acc);
                    fe_nx    = 1'b1;
                    state_nx = PARITY;
                end else begin
                    out_nx = sh[0];
                    acc_nx = acc ^ sh[0];
                    sh_nx  = {1'b0, sh[WIDTH-1:1]};
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                // IDLE and PARITY both accept; from PARITY this gives gapless frames
                if (accept) begin
                    state_nx = SHIFT;
                    out_nx   = data_in[0];
                    vld_nx   = 1'b1;
                    fe_nx    = 1'b0;
                    acc_nx   = data_in[0];
                    sh_nx    = {1'b0, data_in[WIDTH-1:1]};
                    cnt_nx   = '0;
                end else begin
                    state_nx = IDLE;
                    out_nx   = 1'b0;
                    vld_nx   = 1'b0;
                    fe_nx    = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_parity_tx.sv
// Bench for parity_tx: an odd-mode and an even-mode instance share stimulus and are
// compared every cycle against a frame-level queue model plus a running-parity receiver.
module tb_parity_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] data_in = '0;

    logic ready1, out1, vld1, fe1;
    logic ready0, out0, vld0, fe0;

    parity_tx #(.WIDTH(W), .ODD(1'b1)) dut_odd (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load),
        .ready(ready1), .out(out1), .out_valid(vld1), .frame_end(fe1)
    );

    parity_tx #(.WIDTH(W), .ODD(1'b0)) dut_even (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load),
        .ready(ready0), .out(out0), .out_valid(vld0), .frame_end(fe0)
    );

    always #5 clk = ~clk;

    // One entry per upcoming valid cycle; q[0] is what out shows right now
    typedef struct {
        bit b_odd;
        bit b_even;
        bit fe;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic racc = 1'b0;
    logic exp_rdy;
    bit   mdl_rdy;

    function automatic void push_frame(input logic [W-1:0] d);
        int ones;
        ones = $countones(d);
        for (int i = 0; i < W; i++) q.push_back('{d[i], d[i], 1'b0});
        q.push_back('{(ones % 2 == 0), (ones % 2 == 1), 1'b1});
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Model advance: inputs are stable at the posedge (driven 2 time units after it)
    always @(posedge clk) begin
        if (reset) begin
            mdl_rdy = (q.size() <= 1);
            if (q.size() > 0) void'(q.pop_front());
            if (load && mdl_rdy) push_frame(data_in);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            racc = 1'b0;
        end
        exp_rdy = reset && (q.size() <= 1);
        chk("ready_odd", ready1, exp_rdy);
        chk("ready_even", ready0, exp_rdy);
        if (q.size() == 0) begin
            chk("out_idle_odd", out1, 1'b0);
            chk("vld_idle_odd", vld1, 1'b0);
            chk("fe_idle_odd", fe1, 1'b0);
            chk("out_idle_even", out0, 1'b0);
            chk("vld_idle_even", vld0, 1'b0);
            chk("fe_idle_even", fe0, 1'b0);
        end else begin
            chk("out_odd", out1, q[0].b_odd);
            chk("vld_odd", vld1, 1'b1);
            chk("fe_odd", fe1, q[0].fe);
            chk("out_even", out0, q[0].b_even);
            chk("vld_even", vld0, 1'b1);
            chk("fe_even", fe0, q[0].fe);
        end
        if (vld1 === 1'b1) begin
            racc = racc ^ out1;
            if (fe1 === 1'b1) begin
                chk("rx_accept", racc, 1'b1);
                racc = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [W-1:0] d);
        for (int n = 0; n < 40 && q.size() > 1; n++) step(1);
        checks++;
        assert (q.size() <= 1) else begin
            errors++;
            $error("FAIL send_timeout observed=%0d expected=<=1", q.size());
        end
        data_in = d;
        load = 1'b1;
        step(1);
        load = 1'b0;
        data_in = W'($urandom);
    endtask

    initial begin
        // Reset held with load asserted; accept happens on the first edge after release
        reset = 1'b0;
        load = 1'b1;
        data_in = 8'hA5;
        step(3);
        reset = 1'b1;
        step(1);
        load = 1'b0;
        data_in = 8'h5A;
        step(12);

        send(8'h07); step(12);
        send(8'h00); step(12);
        send(8'hFF); step(12);

        // Back-to-back frames with load held high
        data_in = 8'h01;
        load = 1'b1;
        step(1);
        data_in = 8'h03;
        step(9);
        load = 1'b0;
        step(12);

        // Load pulse while busy must be ignored
        send(8'h0F);
        step(3);
        data_in = 8'hF0;
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(12);

        // Mid-frame reset
        send(8'hA5);
        step(2);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        send(8'h01);
        step(12);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                send(W'($urandom));
                step(int'($urandom_range(0, 10)));
            end else if (r == 6) begin
                load = 1'b1;
                for (int k = 0; k < int'($urandom_range(5, 25)); k++) begin
                    data_in = W'($urandom);
                    step(1);
                end
                load = 1'b0;
            end else if (r == 7) begin
                data_in = W'($urandom);
                load = 1'b1;
                step(1);
                load = 1'b0;
                step(int'($urandom_range(0, 4)));
            end else if (r == 8) begin
                step(int'($urandom_range(1, 12)));
            end else begin
                step(int'($urandom_range(0, 8)));
                reset = 1'b0;
                step(int'($urandom_range(1, 2)));
                reset = 1'b1;
            end
        end
        load = 1'b0;
        step(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_tx.md
Name: parity_tx

Overview:
Serial parity transmitter, the sending end of the team's serial parity-check link. Accepts a parallel WIDTH-bit word through a valid/ready handshake and shifts it out LSB-first, one bit per clock. It then appends one parity bit so that the whole (WIDTH+1)-bit frame has the configured parity. A running-parity receiver sampling `out` while `out_valid` is high therefore reads "accept" (1 for odd mode) at every frame end.

Parameters:
WIDTH, 8, data bits per frame (>= 2)
ODD, 1, 1 = frame has an odd number of ones; 0 = even number of ones

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  asynchronous, active-low reset (0 = in reset)
data_in  input  WIDTH  word to transmit; sampled only on an accept
load  input  1  request to send data_in
ready  output  1  block can accept a word this cycle
out  output  1  serial data/parity bit, registered
out_valid  output  1  `out` carries a frame bit this cycle, registered
frame_end  output  1  high exactly in the cycle `out` carries the parity bit

Behaviour:
- States: IDLE, SHIFT, PARITY. Bit counter is clog2(WIDTH) bits wide; a shift register holds the word; a running parity accumulator tracks the ones count.
- Reset (reset==0, asynchronous): state=IDLE; out=0, out_valid=0, frame_end=0; counter, shift register and accumulator cleared.
- ready = reset && (state==IDLE || state==PARITY). It is combinational from state, and 0 while in reset.
- Accept = load && ready at a posedge. data_in is captured and the state goes to SHIFT.
- Timing: the cycle after accept, out=data_in[0] and out_valid=1. Bits 1..WIDTH-1 follow on consecutive cycles. The parity bit follows in cycle WIDTH+1 after accept.
- Parity bit = (XOR of data bits) ^ ODD. For ODD=1 this is the complement of the XOR.
- SHIFT -> PARITY after bit WIDTH-1 has been driven. During PARITY: frame_end=1, out_valid=1.
- PARITY -> SHIFT if an accept occurs in the PARITY cycle. Back-to-back frames then have zero gap cycles.
- PARITY -> IDLE otherwise. In IDLE: out=0, out_valid=0, frame_end=0.
- load while ready==0 is ignored. data_in is not sampled and the frame in flight is undisturbed.
- data_in changing after accept has no effect on the current frame.
- Reset asserted mid-frame: the frame is abandoned immediately and outputs take reset values. After release, the first accepted word starts a fresh frame at bit 0, with the accumulator cleared.
- Throughput: one frame per WIDTH+1 cycles when load is held high.

Decomposition:
- Shared package parity_pkg holds:
  - state encoding typedef (IDLE, SHIFT, PARITY);
  - constants PAR_EVEN=0 and PAR_ODD=1.
- No sub-module. Counter, shifter and accumulator are small enough to stay inline in parity_tx.

Test Plan:
- Reset: hold reset=0 for 3 cycles with load=1 -> out=0, out_valid=0, frame_end=0, ready=0. First posedge after release -> ready=1, then the accept proceeds.
- WIDTH=8, ODD=1, single load of 8'hA5 -> out sequence 1,0,1,0,0,1,0,1 then parity 1 (5 ones total). frame_end high only on the 9th valid cycle. Next cycle out_valid=0 and ready=1.
- Parity values, ODD=1:
  - 8'h07 -> parity bit 0;
  - 8'h00 -> parity bit 1;
  - 8'hFF -> parity bit 1.
  - With ODD=0, 8'h07 -> parity bit 1.
- Back-to-back: load held high with 8'h01 then 8'h03 -> 18 consecutive out_valid cycles, no gap. Parity bits are 0 then 1; frame_end pulses in valid cycles 9 and 18.
- Busy load: accept 8'h0F, then pulse load with data_in=8'hF0 during bit 3 -> pulse ignored. Stream is exactly 1,1,1,1,0,0,0,0 then parity 1.
- Mid-frame reset: drop reset for 1 cycle after bit 2 of 8'hA5 -> out_valid falls asynchronously. After release, loading 8'h01 yields 1,0,0,0,0,0,0,0 then parity 0.
- A running-parity bench model fed from `out`/`out_valid` must read 1 at every frame_end in all scenarios with ODD=1.
